reg_dump_unit: RTL and testbench

Sequential reader for the 32 x 32-bit `register_file`: on a `start` pulse it walks register indices 0..REG_COUNT-1 through one register-file read port and streams each word out over a valid/ready interface, tagged with its index and a last flag. It sits beside the register file in the datapath and drives one `read_reg` / `read_data` pair. It is used to dump architectural state at end of simulation or on a debug request. It never writes the register file.

---
 rtl/reg_dump_unit.sv | 118 +++++++++++
 tb/tb_reg_dump_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_unit.sv
// Sequential register-file dumper: walks indices 0..REG_COUNT-1 through one read
// port and streams each word out on a valid/ready interface with index and last tag.
module reg_dump_unit #(
    parameter int REG_COUNT = 32,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_read_reg,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_COUNT - 1);

    if (REG_COUNT < 1 || REG_COUNT > (1 << ADDR_W)) begin : g_bad_count
        $error("reg_dump_unit: REG_COUNT out of range for ADDR_W");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_next;
    logic              load_word;
    logic              handshake;

    assign handshake = out_valid & out_ready;

    always_comb begin
        state_next = state;
        idx_next   = idx;
        load_word  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    idx_next   = '0;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                load_word  = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                if (handshake) begin
                    if (out_last) begin
                        state_next = DONE;
                    end else begin
                        idx_next   = idx + 1'b1;
                        state_next = FETCH;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The read port is addressed straight from the counter so the word is captured
    // at the end of the very FETCH cycle that presents its index.
    always_comb begin
        rf_read_reg = (state == IDLE) ? '0 : idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            busy  <= (state_next != IDLE);
            done  <= (state_next == DONE);
            if (load_word) begin
                out_data  <= rf_read_data;
                out_index <= idx;
                out_last  <= (idx == LAST_IDX);
                out_valid <= 1'b1;
            end else if (state == SEND && handshake) begin
                out_valid <= 1'b0;
            end
        end
    end

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data)
                                       && $stable(out_index) && $stable(out_last)));

    a_idx_range: assert property (@(posedge clk) disable iff (rst) idx <= LAST_IDX);

    a_done_quiet: assert property (@(posedge clk) disable iff (rst) done |-> !out_valid);

endmodule

// File: tb/tb_reg_dump_unit.sv
// Bench for reg_dump_unit: vector table, hand-written corner sequences and
// randomized dumps scored against a timing/data reference model.
module tb_reg_dump_unit;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [4:0]  rf_read_reg;
    logic [31:0] rf_read_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_index;
    logic        out_last;

    logic [31:0] regs [N];

    assign rf_read_data = regs[rf_read_reg];

    always #5 clk = ~clk;

    reg_dump_unit #(.REG_COUNT(N), .ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rf_read_reg(rf_read_reg), .rf_read_data(rf_read_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    // Stimulus plans, indexed by cycle relative to the start pulse
    bit rdy_pat [512];
    bit st_pat  [512];
    typedef struct { int cyc; int r; logic [31:0] v; } wr_t;
    wr_t wrq [$];

    // Reference model results
    int          exp_vcyc [N];
    int          exp_done;
    logic [31:0] exp_data [N];

    // Observations
    int          obs_n;
    int          obs_vcyc [64];
    logic [4:0]  obs_idx  [64];
    logic [31:0] obs_data [64];
    bit          obs_last [64];
    int          done_cyc, done_cnt, stab_err, busy_err;

    // Word k becomes valid two cycles after the previous acceptance; it is
    // accepted on the first ready cycle; done follows the last acceptance.
    function automatic void model_timing();
        int v;
        int h;
        v = 2;
        h = 2;
        for (int k = 0; k < N; k++) begin
            exp_vcyc[k] = v;
            h = v;
            while (h < 511 && !rdy_pat[h]) h++;
            v = h + 2;
        end
        exp_done = h + 1;
    endfunction

    // A word carries its register's value as of the end of its fetch cycle.
    function automatic void model_data(input logic [31:0] snap [N]);
        for (int k = 0; k < N; k++) begin
            exp_data[k] = snap[k];
            foreach (wrq[i])
                if (wrq[i].r == k && wrq[i].cyc <= exp_vcyc[k] - 1) exp_data[k] = wrq[i].v;
        end
    endfunction

    task automatic run_dump(input string tag);
        logic [31:0] snap [N];
        bit pending;
        bit exp_busy;
        for (int i = 0; i < N; i++) snap[i] = regs[i];
        model_timing();
        model_data(snap);
        obs_n = 0; done_cnt = 0; done_cyc = -1; stab_err = 0; busy_err = 0;
        pending = 0;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            exp_busy = (t >= 1 && t <= exp_done);
            if (busy !== exp_busy) busy_err++;
            if (done === 1'b1) begin done_cnt++; done_cyc = t; end
            if (out_valid === 1'b1) begin
                if (!pending) begin
                    if (obs_n < 64) begin
                        obs_vcyc[obs_n] = t;
                        obs_idx[obs_n]  = out_index;
                        obs_data[obs_n] = out_data;
                        obs_last[obs_n] = out_last;
                    end
                    obs_n++;
                end else if (obs_n <= 64 && (out_index !== obs_idx[obs_n-1] ||
                         out_data !== obs_data[obs_n-1] || out_last !== obs_last[obs_n-1])) begin
                    stab_err++;
                end
                pending = !rdy_pat[t];
            end else begin
                pending = 0;
            end
            start     = st_pat[t];
            out_ready = rdy_pat[t];
            foreach (wrq[i]) if (wrq[i].cyc == t) regs[wrq[i].r] = wrq[i].v;
            if (t >= exp_done + 3) break;
        end
        start = 1'b0;
        chk({tag, " word_count"}, obs_n, N);
        for (int k = 0; k < N && k < obs_n; k++) begin
            chk($sformatf("%s idx[%0d]", tag, k), obs_idx[k], k);
            chk($sformatf("%s data[%0d]", tag, k), obs_data[k], exp_data[k]);
            chk($sformatf("%s last[%0d]", tag, k), obs_last[k], k == N - 1);
            chk($sformatf("%s vcyc[%0d]", tag, k), obs_vcyc[k], exp_vcyc[k]);
        end
        chk({tag, " done_count"}, done_cnt, 1);
        chk({tag, " done_cycle"}, done_cyc, exp_done);
        chk({tag, " stall_stable"}, stab_err, 0);
        chk({tag, " busy_window"}, busy_err, 0);
    endtask

    task automatic clear_plan();
        for (int i = 0; i < 512; i++) begin rdy_pat[i] = 1'b1; st_pat[i] = 1'b0; end
        st_pat[0] = 1'b1;
        wrq.delete();
    endtask

    task automatic preload_x3();
        for (int i = 0; i < N; i++) regs[i] = 32'(i * 3);
    endtask

    typedef struct {
        bit         start;
        bit         ready;
        bit         e_busy;
        bit         e_valid;
        logic [4:0] e_index;
        logic [31:0] e_data;
        bit         e_last;
        bit         e_done;
        logic [4:0] e_rreg;
    } vec_t;

    initial begin
        vec_t vt [9];
        int   wr_c;

        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [9];
        int   c;

        preload_x3();
        rst = 1'b1; start = 1'b1; out_ready = 1'b0;

        // Reset with start held high
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_last", out_last, 0);
        chk("rst out_data", out_data, 0);
        chk("rst out_index", out_index, 0);
        chk("rst rf_read_reg", rf_read_reg, 0);
        rst = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle busy", busy, 0);
        chk("idle out_valid", out_valid, 0);

        // Cycle table from idle: stall on word 0, stray start during FETCH 1
        vt[0] = '{1, 1, 0, 0, 5'd0, 32'd0, 0, 0, 5'd0};
        vt[1] = '{0, 0, 1, 0, 5'd0, 32'd0, 0, 0, 5'd0};
        vt[2] = '{0, 0, 1, 1, 5'd0, 32'd0, 0, 0, 5'd0};
        vt[3] = '{0, 1, 1, 1, 5'd0, 32'd0, 0, 0, 5'd0};
        vt[4] = '{1, 1, 1, 0, 5'd0, 32'd0, 0, 0, 5'd1};
        vt[5] = '{0, 1, 1, 1, 5'd1, 32'd3, 0, 0, 5'd1};
        vt[6] = '{0, 1, 1, 0, 5'd1, 32'd3, 0, 0, 5'd2};
        vt[7] = '{0, 1, 1, 1, 5'd2, 32'd6, 0, 0, 5'd2};
        vt[8] = '{0, 1, 1, 0, 5'd2, 32'd6, 0, 0, 5'd3};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d busy", i), busy, vt[i].e_busy);
            chk($sformatf("vec%0d valid", i), out_valid, vt[i].e_valid);
            chk($sformatf("vec%0d index", i), out_index, vt[i].e_index);
            chk($sformatf("vec%0d data", i), out_data, vt[i].e_data);
            chk($sformatf("vec%0d last", i), out_last, vt[i].e_last);
            chk($sformatf("vec%0d done", i), done, vt[i].e_done);
            chk($sformatf("vec%0d rreg", i), rf_read_reg, vt[i].e_rreg);
            start = vt[i].start; out_ready = vt[i].ready;
        end
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Full dump, no backpressure
        clear_plan(); preload_x3();
        run_dump("full");
        chk("full done_at_65", done_cyc, 65);

        // Backpressure while word 4 (cycle 10) is valid
        clear_plan(); preload_x3();
        for (int t = 10; t < 15; t++) rdy_pat[t] = 1'b0;
        run_dump("bp");
        chk("bp done_at_70", done_cyc, 70);
        chk("bp word5_cycle", obs_vcyc[5], 17);

        // start while busy
        clear_plan(); preload_x3();
        st_pat[10] = 1'b1; st_pat[65] = 1'b1;
        run_dump("restart");
        repeat (4) @(negedge clk);
        chk("restart stays_idle", busy, 0);

        // Concurrent writes: reg 20 during FETCH of index 10, reg 5 after its fetch
        clear_plan(); preload_x3();
        wrq.push_back('{21, 20, 32'hDEADBEEF});
        wrq.push_back('{30, 5, 32'h12345678});
        run_dump("wr");
        chk("wr reg20_new", obs_data[20], 32'hDEADBEEF);
        chk("wr reg5_old", obs_data[5], 32'd15);

        // Reset while word 12 is valid
        preload_x3();
        out_ready = 1'b1;
        for (int t = 0; t <= 26; t++) begin
            @(negedge clk);
            start = (t == 0);
        end
        chk("mid word12_valid", out_valid, 1);
        chk("mid word12_index", out_index, 12);
        rst = 1'b1;
        @(negedge clk);
        chk("mid valid_cleared", out_valid, 0);
        chk("mid busy_cleared", busy, 0);
        rst = 1'b0;
        c = 0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) c++;
        end
        chk("mid no_done", c, 0);
        clear_plan();
        run_dump("after_rst");

        // Randomized dumps
        for (int it = 0; it < 4; it++) begin
            int wc;
            clear_plan();
            for (int i = 0; i < N; i++) regs[i] = $urandom;
            for (int t = 1; t < 500; t++) rdy_pat[t] = ($urandom_range(0, 9) < 7);
            model_timing();
            for (int j = 0; j < 3; j++) st_pat[$urandom_range(1, exp_done)] = 1'b1;
            wc = 0;
            for (int j = 0; j < 8; j++) begin
                wc += $urandom_range(1, 15);
                wrq.push_back('{wc, int'($urandom_range(0, N - 1)), $urandom});
            end
            run_dump($sformatf("rnd%0d", it));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
